// File: rtl/faa_adder_if.sv
// Bus interface for faa_adder.
// Groups the operand/qualifier inputs and the registered result outputs.
//   master : drives in_valid, x, y, ci; observes s, co, out_valid (and ovf)
//   slave  : the adder; observes the operands and drives the results
// Optional macro FAA_OVF_EN adds the ovf signal (signed overflow flag).
interface faa_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             out_valid;
`ifdef FAA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid,
    output x,
    output y,
    output ci,
    input  s,
    input  co,
`ifdef FAA_OVF_EN
    input  ovf,
`endif
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  x,
    input  y,
    input  ci,
    output s,
    output co,
`ifdef FAA_OVF_EN
    output ovf,
`endif
    output out_valid
  );
endinterface

// File: rtl/faa_adder.sv
// Registered WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
// {co, s} = x + y + ci, captured one clock after in_valid; results hold while
// in_valid is low, out_valid pulses once per accepted input.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : faa_adder_if.slave (in_valid, x, y, ci -> s, co, out_valid[, ovf])
// Optional macro FAA_OVF_EN adds the registered signed-overflow output ovf.

// 1-bit full-adder cell.
module faa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module faa_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  faa_adder_if.slave   bus
);

  // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_w;

  assign carry[0] = bus.ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    faa_cell u_cell (
      .a    (bus.x[i]),
      .b    (bus.y[i]),
      .cin  (carry[i]),
      .sum  (sum_w[i]),
      .cout (carry[i+1])
    );
  end

  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             vld_q, vld_d;

  // Operands are only looked at when qualified, so X/Z on idle inputs never
  // reaches the result registers.
  always_comb begin
    s_d   = s_q;
    co_d  = co_q;
    vld_d = 1'b0;
    if (bus.in_valid) begin
      s_d   = sum_w;
      co_d  = carry[WIDTH];
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      co_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      co_q  <= co_d;
      vld_q <= vld_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.co        = co_q;
  assign bus.out_valid = vld_q;

`ifdef FAA_OVF_EN
  logic ovf_q, ovf_d;

  // Two's-complement overflow: carry into the MSB differs from carry out.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.in_valid) begin
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_faa_adder.sv
// Self-checking bench for faa_adder (WIDTH=4). Expected results are pushed to
// a scoreboard queue when a valid input is driven and popped when out_valid
// is seen. Build with +define+FAA_OVF_EN to also check ovf.
module tb_faa_adder;

  logic clk;
  logic rst_n;

  faa_adder_if #(.WIDTH(4)) bus ();

  faa_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Scoreboard entry: {ovf, co, s[3:0]}
  logic [5:0] sb [$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic c);
    logic [4:0] t;
    logic       ov;
    t  = {1'b0, a} + {1'b0, b} + {4'b0, c};
    ov = (a[3] == b[3]) && (t[3] != a[3]);
    return {ov, t};
  endfunction

  // Bench-side model of out_valid: one-cycle delayed in_valid, cleared by reset.
  logic exp_vld;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_vld <= 1'b0;
    else        exp_vld <= bus.in_valid;
  end

  // Monitor: sampled on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst_n) begin
      check_val("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_vld});
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("s",  {28'b0, bus.s},  {28'b0, e[3:0]});
          check_val("co", {31'b0, bus.co}, {31'b0, e[4]});
`ifdef FAA_OVF_EN
          check_val("ovf", {31'b0, bus.ovf}, {31'b0, e[5]});
`endif
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic c);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.x        = a;
    bus.y        = b;
    bus.ci       = c;
    if (v) sb.push_back(model(a, b, c));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.ci       = 1'b0;
    #12;
    check_val("rst_s",   {28'b0, bus.s},         32'd0);
    check_val("rst_co",  {31'b0, bus.co},        32'd0);
    check_val("rst_vld", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Basic add, then hold s=9 and reset asynchronously mid-cycle.
    drive(1'b1, 4'h5, 4'h3, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    check_val("held_s9", {28'b0, bus.s}, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_s",   {28'b0, bus.s},         32'd0);
    check_val("async_rst_co",  {31'b0, bus.co},        32'd0);
    check_val("async_rst_vld", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    check_val("release_s", {28'b0, bus.s}, 32'd0);

    // Carry / wrap corners and signed-overflow vectors.
    drive(1'b1, 4'hF, 4'h1, 1'b0);
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    drive(1'b1, 4'h7, 4'h1, 1'b0);
    drive(1'b1, 4'h8, 4'h8, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // Sweep: back-to-back valid inputs.
    for (int unsigned i = 0; i < 100; i++) begin
      drive(1'b1, 4'(i), 4'(i / 2), 1'b0);
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    // Hold: s must stay 4 while idle inputs toggle (including X).
    drive(1'b1, 4'h2, 4'h2, 1'b0);
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (i == 3) begin
        bus.x  = 'x;
        bus.y  = 'x;
        bus.ci = 1'bx;
      end else begin
        bus.x  = 4'($urandom);
        bus.y  = 4'($urandom);
        bus.ci = 1'($urandom);
      end
      @(negedge clk);
      check_val("hold_s", {28'b0, bus.s}, 32'd4);
    end

    // Reset mid-stream: in-flight input is discarded.
    drive(1'b1, 4'h3, 4'h4, 1'b0);
    #2 rst_n = 1'b0;
    sb.delete();
    bus.in_valid = 1'b0;
    #1;
    check_val("mid_rst_vld", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    check_val("post_rst_s", {28'b0, bus.s}, 32'd0);
    drive(1'b1, 4'h1, 4'hA, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0);

    @(negedge clk);
    check_val("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
